// File: rtl/seq_control_fsm.sv
// rtl/seq_control_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the SEQ RV64 core
// Optional SEQ_CTRL_PERF_EN adds instret_o and stall_cycles_o counters.
module seq_control_fsm #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TMO_W       = 5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       alu_zero_i,
   input  logic       imem_ready_i,
   input  logic       dmem_ready_i,
   output logic       imem_req_o,
   output logic       ir_write_o,
   output logic       dmem_req_o,
   output logic       dmem_we_o,
   output logic       alu_src_imm_o,
   output logic       reg_write_o,
   output logic       pc_write_o,
   output logic [1:0] pc_sel_o,
   output logic       halted_o,
   output logic       fault_o,
`ifdef SEQ_CTRL_PERF_EN
   output logic [31:0] instret_o,
   output logic [31:0] stall_cycles_o,
`endif
   output logic [2:0] state_out_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_FAULT  = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      C_NONE, C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC
   } class_e;

   localparam logic [6:0]       OP_SYSTEM = 7'b1110011;
   localparam logic [TMO_W-1:0] TMO_LAST  = (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   class_e           class_q, class_d, dec_class;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             wait_cyc;
   logic             tmo_hit;
   logic             unused_funct3;

   assign unused_funct3 = &{1'b0, funct3_i[2:1]};

   always_comb begin
      case (opcode_i)
         7'b0110011: dec_class = C_R;
         7'b0010011: dec_class = C_I;
         7'b0000011: dec_class = C_LD;
         7'b0100011: dec_class = C_ST;
         7'b1100011: dec_class = C_BR;
         7'b1101111: dec_class = C_JAL;
         7'b1100111: dec_class = C_JALR;
         7'b0110111: dec_class = C_LUI;
         7'b0010111: dec_class = C_AUIPC;
         default:    dec_class = C_NONE;
      endcase
   end

   assign wait_cyc = ((state_q == S_FETCH) && !imem_ready_i) ||
                     ((state_q == S_MEM)   && !dmem_ready_i);
   // tmo_q counts wait cycles already spent; the last allowed wait cycle faults unless ready arrives
   assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         class_q <= C_NONE;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      class_d = class_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_FETCH;
               tmo_d   = '0;
            end
         end
         S_FETCH: begin
            if (imem_ready_i) begin
               state_d = S_DECODE;
            end else if (tmo_hit) begin
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DECODE: begin
            class_d = dec_class;
            if (opcode_i == OP_SYSTEM) begin
               state_d = S_HALT;
            end else if (dec_class == C_NONE) begin
               state_d = S_FAULT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (class_q)
               C_BR: begin
                  state_d = S_FETCH;
                  tmo_d   = '0;
               end
               C_LD, C_ST: begin
                  state_d = S_MEM;
                  tmo_d   = '0;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready_i) begin
               tmo_d   = '0;
               state_d = (class_q == C_LD) ? S_WB : S_FETCH;
            end else if (tmo_hit) begin
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            tmo_d   = '0;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      imem_req_o    = 1'b0;
      ir_write_o    = 1'b0;
      dmem_req_o    = 1'b0;
      dmem_we_o     = 1'b0;
      alu_src_imm_o = 1'b0;
      reg_write_o   = 1'b0;
      pc_write_o    = 1'b0;
      pc_sel_o      = 2'd0;
      halted_o      = 1'b0;
      fault_o       = 1'b0;
      state_out_o   = state_q;
      case (state_q)
         S_FETCH: begin
            imem_req_o = 1'b1;
            ir_write_o = imem_ready_i;
         end
         S_EXEC: begin
            alu_src_imm_o = (class_q != C_R) && (class_q != C_BR);
            if (class_q == C_BR) begin
               pc_write_o = 1'b1;
               pc_sel_o   = (alu_zero_i ^ funct3_i[0]) ? 2'd1 : 2'd0;
            end
         end
         S_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = (class_q == C_ST);
            pc_write_o = dmem_ready_i && (class_q == C_ST);
         end
         S_WB: begin
            reg_write_o = 1'b1;
            pc_write_o  = 1'b1;
            pc_sel_o    = ((class_q == C_JAL) || (class_q == C_JALR)) ? 2'd2 : 2'd0;
         end
         S_HALT:  halted_o = 1'b1;
         S_FAULT: fault_o  = 1'b1;
         default: ;
      endcase
   end

`ifdef SEQ_CTRL_PERF_EN
   logic [31:0] instret_q, stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instret_q <= '0;
         stall_q   <= '0;
      end else begin
         instret_q <= instret_q + {31'd0, pc_write_o};
         stall_q   <= stall_q + {31'd0, wait_cyc};
      end
   end

   assign instret_o      = instret_q;
   assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_seq_control_fsm.sv
// tb/tb_seq_control_fsm.sv - scoreboard bench for seq_control_fsm with random instruction stream
// Retire events are predicted from per-class latency and pc_sel rules, then directed corner cases.
module tb_seq_control_fsm;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       az;
      int         iwait;
      int         dwait;
   } plan_t;

   typedef struct {
      int         start;
      int         lat;
      logic [1:0] sel;
      logic       rw;
      int         dm;
      logic       we;
      int         imm;
   } exp_t;

   // class order: R I LD ST BR JAL JALR LUI AUIPC
   localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   localparam int         BASE[9] = '{4, 4, 5, 4, 3, 4, 4, 4, 4};
   localparam logic [6:0] OP_SYS  = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst_n, start, alu_zero, imem_ready, dmem_ready;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       imem_req, ir_write, dmem_req, dmem_we, alu_src_imm, reg_write, pc_write;
   logic       halted, fault;
   logic [1:0] pc_sel;
   logic [2:0] state_out;
`ifdef SEQ_CTRL_PERF_EN
   logic [31:0] instret, stall_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int retired = 0;
   int exp_retire = 0;
   int exp_stall = 0;
   logic auto_mode = 1'b0;
   logic mon_en = 1'b0;
   plan_t stim_q[$];
   exp_t  sb[$];

   seq_control_fsm #(.MEM_TIMEOUT(16), .TMO_W(5)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .opcode_i(opcode), .funct3_i(funct3),
      .alu_zero_i(alu_zero), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
      .imem_req_o(imem_req), .ir_write_o(ir_write), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
      .alu_src_imm_o(alu_src_imm), .reg_write_o(reg_write), .pc_write_o(pc_write),
      .pc_sel_o(pc_sel), .halted_o(halted), .fault_o(fault),
`ifdef SEQ_CTRL_PERF_EN
      .instret_o(instret), .stall_cycles_o(stall_cycles),
`endif
      .state_out_o(state_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int kind_of(input logic [6:0] op);
      for (int k = 0; k < 9; k++) if (OPS[k] == op) return k;
      return -1;
   endfunction

   function automatic exp_t model(input plan_t p, input int start_cyc);
      exp_t e;
      int   k;
      logic mem;
      k       = kind_of(p.op);
      mem     = (k == 2) || (k == 3);
      e.start = start_cyc;
      e.lat   = BASE[k] + p.iwait + (mem ? p.dwait : 0);
      e.sel   = (k == 4) ? ((p.az != p.f3[0]) ? 2'd1 : 2'd0) : ((k == 5 || k == 6) ? 2'd2 : 2'd0);
      e.rw    = !((k == 3) || (k == 4));
      e.dm    = mem ? p.dwait + 1 : 0;
      e.we    = (k == 3);
      e.imm   = (k == 0 || k == 4) ? 0 : 1;
      return e;
   endfunction

   // memory responder: issues the next planned instruction and paces the ready lines
   initial begin
      plan_t cur;
      int icnt, dcnt;
      icnt = 0; dcnt = 0;
      cur = '{op: 7'd0, f3: 3'd0, az: 1'b0, iwait: 0, dwait: 0};
      forever begin
         step();
         if (auto_mode) begin
            if (imem_req) begin
               if (icnt == 0) begin
                  if (stim_q.size() != 0) begin
                     cur = stim_q.pop_front();
                     if (cur.op != OP_SYS) sb.push_back(model(cur, cyc));
                  end else begin
                     cur.iwait = 1 << 20;
                  end
                  opcode   = cur.op;
                  funct3   = cur.f3;
                  alu_zero = cur.az;
               end
               imem_ready = (icnt == cur.iwait);
               icnt++;
            end else begin
               imem_ready = 1'b0;
               icnt = 0;
            end
            if (dmem_req) begin
               dmem_ready = (dcnt == cur.dwait);
               dcnt++;
            end else begin
               dmem_ready = 1'b0;
               dcnt = 0;
            end
         end else begin
            icnt = 0;
            dcnt = 0;
         end
      end
   end

   // monitor: per-instruction activity is tallied and compared on each pc_write
   initial begin
      exp_t e;
      int dm_cnt, imm_cnt;
      logic we_seen;
      dm_cnt = 0; imm_cnt = 0; we_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) chk("req_exclusive", {63'd0, imem_req & dmem_req}, 64'd0);
         if (!mon_en) begin
            dm_cnt = 0; imm_cnt = 0; we_seen = 1'b0;
         end else begin
            chk("reg_write_without_pc_write", {63'd0, reg_write & ~pc_write}, 64'd0);
            if (dmem_req) begin
               dm_cnt++;
               if (dmem_we) we_seen = 1'b1;
            end
            if (alu_src_imm) imm_cnt++;
            if (pc_write) begin
               chk("retire_expected", {63'd0, sb.size() != 0}, 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("latency", 64'(cyc - e.start + 1), 64'(e.lat));
                  chk("pc_sel", {62'd0, pc_sel}, {62'd0, e.sel});
                  chk("reg_write", {63'd0, reg_write}, {63'd0, e.rw});
                  chk("dmem_req_cycles", 64'(dm_cnt), 64'(e.dm));
                  chk("dmem_we", {63'd0, we_seen}, {63'd0, e.we});
                  chk("alu_src_imm_cycles", 64'(imm_cnt), 64'(e.imm));
               end
               retired++;
               dm_cnt = 0; imm_cnt = 0; we_seen = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      auto_mode  = 1'b0;
      mon_en     = 1'b0;
      rst_n      = 1'b0;
      start      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic add_plan(input logic [6:0] op, input logic [2:0] f3, input logic az,
                           input int iw, input int dw);
      plan_t p;
      int    k;
      p = '{op: op, f3: f3, az: az, iwait: iw, dwait: dw};
      stim_q.push_back(p);
      k = kind_of(op);
      exp_stall += iw + ((k == 2 || k == 3) ? dw : 0);
      if (op != OP_SYS) exp_retire++;
   endtask

   function automatic int rand_wait();
      return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; alu_zero = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {61'd0, state_out}, 64'd0);
      chk("reset_outputs", {54'd0, imem_req, ir_write, dmem_req, dmem_we, alu_src_imm,
                            reg_write, pc_write, pc_sel, halted, fault}, 64'd0);
      step();
      rst_n = 1'b1;

      add_plan(OPS[0], 3'b000, 1'b0, 0, 0);
      add_plan(OPS[4], 3'b000, 1'b1, 0, 0);
      add_plan(OPS[4], 3'b000, 1'b0, 0, 0);
      add_plan(OPS[4], 3'b001, 1'b0, 0, 0);
      add_plan(OPS[2], 3'b011, 1'b0, 0, 3);
      add_plan(OPS[3], 3'b011, 1'b0, 15, 15);
      for (int n = 0; n < 40; n++) begin
         add_plan(OPS[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  rand_wait(), rand_wait());
      end
      add_plan(OP_SYS, 3'b000, 1'b0, 0, 0);

      auto_mode = 1'b1;
      mon_en    = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6000 && state_out != 3'd6; i++) step();
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("halt_state", {61'd0, state_out}, 64'd6);
      chk("halted_flag", {63'd0, halted}, 64'd1);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      chk("retired_count", 64'(retired), 64'(exp_retire));
`ifdef SEQ_CTRL_PERF_EN
      chk("instret", {32'd0, instret}, 64'(exp_retire));
      chk("stall_cycles", {32'd0, stall_cycles}, 64'(exp_stall));
`endif

      // fetch timeout: sixteen wait cycles end in FAULT
      do_reset();
      opcode = OPS[0];
      start  = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("tmo_fetch_enter", {61'd0, state_out}, 64'd1);
      repeat (15) step();
      @(negedge clk);
      chk("tmo_fetch_16th", {61'd0, state_out}, 64'd1);
      step();
      @(negedge clk);
      chk("tmo_fault_state", {61'd0, state_out}, 64'd7);
      chk("tmo_fault_flag", {62'd0, fault, imem_req}, 64'd2);

      // ready on the sixteenth fetch cycle still wins
      do_reset();
      opcode = OPS[0];
      start  = 1'b1;
      step();
      start = 1'b0;
      repeat (15) step();
      imem_ready = 1'b1;
      @(negedge clk);
      chk("tmo_ready_ir_write", {63'd0, ir_write}, 64'd1);
      step();
      imem_ready = 1'b0;
      @(negedge clk);
      chk("tmo_ready_decode", {61'd0, state_out}, 64'd2);
      chk("tmo_ready_no_fault", {63'd0, fault}, 64'd0);

      // illegal opcode faults with no PC update
      do_reset();
      opcode     = 7'b1111111;
      imem_ready = 1'b1;
      start      = 1'b1;
      step();
      start = 1'b0;
      step();
      imem_ready = 1'b0;
      step();
      @(negedge clk);
      chk("illegal_fault_state", {61'd0, state_out}, 64'd7);
      chk("illegal_fault_outputs", {61'd0, fault, pc_write, reg_write}, 64'd4);

      // reset during a store's MEM phase abandons the access at once
      do_reset();
      opcode     = OPS[3];
      imem_ready = 1'b1;
      start      = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("st_mem_req", {62'd0, dmem_req, dmem_we}, 64'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_state", {61'd0, state_out}, 64'd0);
      chk("rst_mid_dmem_req", {63'd0, dmem_req}, 64'd0);
      step();
      rst_n = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("restart_fetch", {61'd0, state_out}, 64'd1);
      chk("restart_reqs", {62'd0, imem_req, dmem_req}, 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
